sigma_delta_dac_mc: RTL and testbench

Multi-channel sigma-delta DAC front end with sample buffering, sitting between the synth's sample-producing pipeline and the output pins. It accepts whole frames (one sample per channel) through a valid/ready handshake into a small FIFO, pops one frame per sample-rate trigger, and saturates each channel to the modulator range. It also drives one first-order 1-bit sigma-delta modulator per channel. Compared with the single-channel wrapper, it adds channel count, a buffer depth, underrun handling, mute and status outputs.

---
 rtl/sigma_delta_dac_mc.sv | 139 +++++++++++++
 tb/tb_sigma_delta_dac_mc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_dac_mc.sv
// rtl/sigma_delta_dac_mc.sv - multi-channel sigma-delta DAC with frame FIFO, saturation and mute
module sigma_delta_dac_mc #(
    parameter int NCH           = 2,
    parameter int IN_W          = 18,
    parameter int MBITS         = 16,
    parameter int DEPTH         = 4,
    parameter int UNDERRUN_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [NCH*IN_W-1:0]      s_data,
    input  logic                     smpl_rate_trig,
    input  logic                     mute,
    output logic [NCH-1:0]           dout,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = MBITS + 1;

    logic [NCH*IN_W-1:0]     mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    s_ready_q, s_ready_d;
    logic                    underrun_q, underrun_d;
    logic                    push, pop;
    logic signed [DW-1:0]    dac_smpl_q [NCH];
    logic signed [DW-1:0]    dac_smpl_d [NCH];
    logic [MBITS:0]          acc_q [NCH];
    logic [MBITS:0]          acc_d [NCH];
    logic [MBITS:0]          u_w [NCH];
    logic [MBITS+1:0]        sum_w [NCH];
    logic [NCH-1:0]          dout_q, dout_d;
    logic [NCH*IN_W-1:0]     head_frame;

    // Clamp to the signed MBITS+1 range accepted by the modulator.
    function automatic logic signed [DW-1:0] sat(input logic signed [IN_W-1:0] x);
        longint xv;
        longint lim;
        xv  = longint'(x);
        lim = longint'(1) <<< MBITS;
        if (xv > lim - 1)
            return {1'b0, {MBITS{1'b1}}};
        else if (xv < -lim)
            return {1'b1, {MBITS{1'b0}}};
        else
            return DW'(x);
    endfunction

    assign head_frame = mem_q[rd_ptr_q];

    always_comb begin
        push       = s_valid & s_ready_q;
        pop        = smpl_rate_trig & (level_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        underrun_d = smpl_rate_trig & (level_q == '0);

        if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        s_ready_d = (level_d != LW'(DEPTH));
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            dac_smpl_d[k] = dac_smpl_q[k];
            if (smpl_rate_trig) begin
                if (mute)
                    dac_smpl_d[k] = '0;
                else if (pop)
                    dac_smpl_d[k] = sat(head_frame[k*IN_W +: IN_W]);
                else if (UNDERRUN_ZERO != 0)
                    dac_smpl_d[k] = '0;
            end
        end
    end

    // Offset binary: adding 2^MBITS to a signed MBITS+1 value flips its MSB.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            u_w[k]    = {~dac_smpl_q[k][MBITS], dac_smpl_q[k][MBITS-1:0]};
            sum_w[k]  = {1'b0, acc_q[k]} + {1'b0, u_w[k]};
            dout_d[k] = sum_w[k][MBITS+1];
            acc_d[k]  = sum_w[k][MBITS:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            s_ready_q  <= 1'b1;
            underrun_q <= 1'b0;
            dout_q     <= '0;
            for (int k = 0; k < NCH; k++) begin
                dac_smpl_q[k] <= '0;
                acc_q[k]      <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            s_ready_q  <= s_ready_d;
            underrun_q <= underrun_d;
            dout_q     <= dout_d;
            for (int k = 0; k < NCH; k++) begin
                dac_smpl_q[k] <= dac_smpl_d[k];
                acc_q[k]      <= acc_d[k];
            end
        end
    end

    assign s_ready  = s_ready_q;
    assign level    = level_q;
    assign underrun = underrun_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// tb/tb_sigma_delta_dac_mc.sv - directed self-checking bench for sigma_delta_dac_mc
module tb_sigma_delta_dac_mc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        trig = 1'b0;
    logic        mute = 1'b0;
    logic [35:0] s_data = '0;

    logic        s_ready0, s_ready1;
    logic [1:0]  dout0, dout1;
    logic        underrun0, underrun1;
    logic [2:0]  level0, level1;

    int n_tests = 0;
    int n_fail  = 0;
    int ones [4];

    // Frames {ch1, ch0}; ch0 ones per 64 cycles: 48, 32, 16, 40, 24 (ch1 is the complement).
    logic [35:0] fr [5];
    int          exp0 [5];

    always #5 clk = ~clk;

    sigma_delta_dac_mc #(.UNDERRUN_ZERO(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready0),
        .s_data(s_data), .smpl_rate_trig(trig), .mute(mute), .dout(dout0),
        .underrun(underrun0), .level(level0)
    );

    sigma_delta_dac_mc #(.UNDERRUN_ZERO(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready1),
        .s_data(s_data), .smpl_rate_trig(trig), .mute(mute), .dout(dout1),
        .underrun(underrun1), .level(level1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [35:0] f);
        s_valid = 1'b1;
        s_data  = f;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic trigger(input logic m);
        trig = 1'b1;
        mute = m;
        @(negedge clk);
        trig = 1'b0;
        mute = 1'b0;
    endtask

    task automatic density(input int n);
        repeat (2) @(negedge clk);
        for (int j = 0; j < 4; j++) ones[j] = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ones[0] += int'(dout0[0]);
            ones[1] += int'(dout0[1]);
            ones[2] += int'(dout1[0]);
            ones[3] += int'(dout1[1]);
        end
    endtask

    initial begin
        fr[0] = {18'h38000, 18'h08000}; exp0[0] = 48;
        fr[1] = {18'h00000, 18'h00000}; exp0[1] = 32;
        fr[2] = {18'h08000, 18'h38000}; exp0[2] = 16;
        fr[3] = {18'h3C000, 18'h04000}; exp0[3] = 40;
        fr[4] = {18'h04000, 18'h3C000}; exp0[4] = 24;

        repeat (2) @(negedge clk);
        check("rst_level", level0, 0);
        check("rst_ready", s_ready0, 1);
        check("rst_dout0", dout0, 0);
        check("rst_dout1", dout1, 0);
        check("rst_underrun", underrun0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("idle_dout0_%0d", i), dout0, (i % 2) ? 3 : 0);
            check($sformatf("idle_dout1_%0d", i), dout1, (i % 2) ? 3 : 0);
        end

        trigger(1'b0);
        check("idle_underrun0", underrun0, 1);
        check("idle_underrun1", underrun1, 1);
        @(negedge clk);
        check("idle_underrun_pulse", underrun0, 0);
        check("idle_level", level0, 0);
        density(64);
        check("idle_density0", ones[0], 32);
        check("idle_density1", ones[2], 32);

        push({18'h20000, 18'h1FFFF});
        check("sat_level_push", level0, 1);
        trigger(1'b0);
        check("sat_level_pop", level0, 0);
        check("sat_no_underrun", underrun0, 0);
        density(200);
        check("sat_ch0_high", ones[0] >= 199, 1);
        check("sat_ch1_zero", ones[1], 0);
        check("sat_dut1_ch0_high", ones[2] >= 199, 1);

        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = fr[i];
            @(negedge clk);
        end
        check("full_level", level0, 4);
        check("full_ready", s_ready0, 0);
        s_data = fr[4];
        repeat (3) @(negedge clk);
        check("full_hold_level", level0, 4);
        check("full_hold_ready", s_ready0, 0);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        check("full_pop_level", level0, 3);
        check("full_pop_ready", s_ready0, 1);
        @(negedge clk);
        s_valid = 1'b0;
        check("full_refill_level", level0, 4);
        check("full_refill_ready", s_ready0, 0);
        density(64);
        check("full_A_ch0", ones[0], exp0[0]);
        check("full_A_ch1", ones[1], 64 - exp0[0]);
        for (int i = 1; i < 5; i++) begin
            trigger(1'b0);
            check($sformatf("full_level_after_%0d", i), level0, 4 - i);
            density(64);
            check($sformatf("full_frame%0d_ch0", i), ones[0], exp0[i]);
            check($sformatf("full_frame%0d_ch1", i), ones[1], 64 - exp0[i]);
        end

        push(fr[0]);
        trigger(1'b0);
        density(64);
        check("ur_load_dut0", ones[0], 48);
        check("ur_load_dut1", ones[2], 48);
        trigger(1'b0);
        check("ur_pulse_dut0", underrun0, 1);
        check("ur_pulse_dut1", underrun1, 1);
        density(64);
        check("ur_hold_dut0", ones[0], 48);
        check("ur_zero_dut1", ones[2], 32);

        s_valid = 1'b1;
        s_data  = fr[4];
        trig    = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        trig    = 1'b0;
        check("sim_underrun", underrun0, 1);
        check("sim_level0", level0, 1);
        check("sim_level1", level1, 1);
        density(64);
        check("sim_hold_dut0", ones[0], 48);
        check("sim_zero_dut1", ones[2], 32);
        trigger(1'b0);
        check("sim_pop_level", level0, 0);
        density(64);
        check("sim_frame_ch0", ones[0], 24);
        check("sim_frame_ch1", ones[1], 40);
        check("sim_frame_dut1", ones[2], 24);

        s_valid = 1'b1;
        s_data  = fr[4];
        trig    = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        trig    = 1'b0;
        check("mute_pre_level", level0, 1);
        trigger(1'b1);
        check("mute_level", level0, 0);
        density(64);
        check("mute_ch0", ones[0], 32);
        check("mute_ch1", ones[1], 32);

        push(fr[0]);
        push(fr[1]);
        push(fr[2]);
        check("mid_level3", level0, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_dout0", dout0, 0);
        check("mid_rst_dout1", dout1, 0);
        check("mid_rst_level", level0, 0);
        check("mid_rst_ready", s_ready0, 1);
        @(negedge clk);
        reset_n = 1'b1;
        push(fr[3]);
        check("post_rst_level", level0, 1);
        trigger(1'b0);
        check("post_rst_pop_level", level0, 0);
        density(64);
        check("post_rst_ch0", ones[0], 40);
        check("post_rst_ch1", ones[1], 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
